rps_round_ctrl: RTL and testbench



---
 rtl/rps_round_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rps_round_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: debounced button, first-order move predictor,
// judging and scoring, and a start/done handshake to the hand-image renderer.
module rps_round_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       go_n,
    input  logic [1:0] user_move,
    output logic [3:0] choice,
    output logic       draw_start,
    input  logic       draw_done,
    output logic [1:0] result,
    output logic [3:0] score_u,
    output logic [3:0] score_c,
    output logic       busy
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MV_ROCK    = 2'b00;
    localparam logic [1:0] MV_SCISSOR = 2'b01;
    localparam logic [1:0] MV_PAPER   = 2'b10;
    localparam logic [1:0] MV_INVALID = 2'b11;

    localparam logic [1:0] RES_TIE  = 2'b00;
    localparam logic [1:0] RES_USER = 2'b01;
    localparam logic [1:0] RES_COMP = 2'b10;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PREDICT   = 3'd1;
    localparam logic [2:0] S_JUDGE     = 3'd2;
    localparam logic [2:0] S_LEARN     = 3'd3;
    localparam logic [2:0] S_DRAW      = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    function automatic logic [1:0] beat(input logic [1:0] m);
        case (m)
            MV_ROCK:    beat = MV_PAPER;
            MV_SCISSOR: beat = MV_ROCK;
            default:    beat = MV_SCISSOR;
        endcase
    endfunction

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        beats = (a == MV_ROCK    && b == MV_SCISSOR) ||
                (a == MV_SCISSOR && b == MV_PAPER)   ||
                (a == MV_PAPER   && b == MV_ROCK);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic             sync_p0, sync_p1;
    logic             btn_lvl;
    logic [CNT_W-1:0] deb_cnt;
    logic             press;

    logic [2:0]       state;
    logic [1:0]       u_lat;
    logic [1:0]       comp;
    logic [1:0]       prev_u;
    logic             prev_valid;
    logic [3:0]       tbl [0:2][0:2];
    logic [1:0]       pred;

    // Synchronizer and debounce: press is a one-cycle pulse on the debounced fall
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            btn_lvl <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= go_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == btn_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                deb_cnt <= '0;
                btn_lvl <= sync_p1;
                press   <= btn_lvl;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Argmax of the row for the previous move; ties resolve rock, then scissor, then paper
    always_comb begin
        pred = MV_PAPER;
        if (tbl[prev_u][0] >= tbl[prev_u][1] && tbl[prev_u][0] >= tbl[prev_u][2])
            pred = MV_ROCK;
        else if (tbl[prev_u][1] >= tbl[prev_u][2])
            pred = MV_SCISSOR;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            u_lat      <= MV_ROCK;
            comp       <= MV_ROCK;
            prev_u     <= MV_ROCK;
            prev_valid <= 1'b0;
            choice     <= '0;
            draw_start <= 1'b0;
            result     <= RES_TIE;
            score_u    <= '0;
            score_c    <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    tbl[i][j] <= '0;
        end else begin
            draw_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press && user_move != MV_INVALID) begin
                        u_lat <= user_move;
                        state <= S_PREDICT;
                    end
                end
                S_PREDICT: begin
                    comp  <= beat(pred);
                    state <= S_JUDGE;
                end
                S_JUDGE: begin
                    if (u_lat == comp) begin
                        result <= RES_TIE;
                    end else if (beats(u_lat, comp)) begin
                        result  <= RES_USER;
                        score_u <= sat_inc4(score_u);
                    end else begin
                        result  <= RES_COMP;
                        score_c <= sat_inc4(score_c);
                    end
                    state <= S_LEARN;
                end
                S_LEARN: begin
                    // A full counter halves its whole row so relative frequencies survive
                    if (prev_valid) begin
                        if (tbl[prev_u][u_lat] == 4'hF) begin
                            for (int j = 0; j < 3; j++)
                                tbl[prev_u][j] <= tbl[prev_u][j] >> 1;
                            tbl[prev_u][u_lat] <= (tbl[prev_u][u_lat] >> 1) + 4'd1;
                        end else begin
                            tbl[prev_u][u_lat] <= tbl[prev_u][u_lat] + 4'd1;
                        end
                    end
                    prev_u     <= u_lat;
                    prev_valid <= 1'b1;
                    choice     <= {comp, u_lat};
                    draw_start <= 1'b1;
                    state      <= S_DRAW;
                end
                S_DRAW: begin
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (draw_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: table of full rounds plus hand-written corner sequences.
module tb_rps_round_ctrl;
    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       go_n     = 1'b1;
    logic [1:0] user_move = 2'b00;
    logic [3:0] choice;
    logic       draw_start;
    logic       draw_done = 1'b0;
    logic [1:0] result;
    logic [3:0] score_u;
    logic [3:0] score_c;
    logic       busy;

    int errors = 0;
    int checks = 0;

    rps_round_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .go_n       (go_n),
        .user_move  (user_move),
        .choice     (choice),
        .draw_start (draw_start),
        .draw_done  (draw_done),
        .result     (result),
        .score_u    (score_u),
        .score_c    (score_c),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit         do_rst;
        logic [1:0] mv;
        logic [3:0] ch;
        logic [1:0] res;
        logic [3:0] su;
        logic [3:0] sc;
    } vec_t;

    vec_t vecs [22];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        go_n      = 1'b1;
        draw_done = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        chk("rst_choice", 32'(choice), 32'h0);
        chk("rst_draw_start", 32'(draw_start), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_scores", 32'({score_u, score_c}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    // Full round: press, check the T+1..T+5 timeline, return draw_done after 10 cycles
    task automatic run_round(input logic [1:0] mv, input logic [3:0] ech, input logic [1:0] eres,
                             input logic [3:0] esu, input logic [3:0] esc);
        int n;
        user_move = mv;
        go_n      = 1'b0;
        n = 0;
        while (!busy && n < 40) begin
            tick();
            n++;
        end
        chk("busy_rise", 32'(busy), 32'h1);
        if (!busy) begin
            go_n = 1'b1;
            return;
        end
        chk("ds_t1", 32'(draw_start), 32'h0);
        tick();
        chk("ds_t2", 32'(draw_start), 32'h0);
        tick();
        chk("ds_t3", 32'(draw_start), 32'h0);
        chk("result_t3", 32'(result), 32'(eres));
        chk("score_u_t3", 32'(score_u), 32'(esu));
        chk("score_c_t3", 32'(score_c), 32'(esc));
        tick();
        chk("ds_t4", 32'(draw_start), 32'h1);
        chk("choice_t4", 32'(choice), 32'(ech));
        tick();
        chk("ds_t5", 32'(draw_start), 32'h0);
        chk("busy_t5", 32'(busy), 32'h1);
        repeat (9) tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("busy_fall", 32'(busy), 32'h0);
        chk("choice_hold", 32'(choice), 32'(ech));
        go_n = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        int nb;
        int nds;
        int n;

        vecs[0] = '{1'b1, 2'b00, 4'b1000, 2'b10, 4'd0, 4'd1};
        vecs[1] = '{1'b1, 2'b01, 4'b1001, 2'b01, 4'd1, 4'd0};
        vecs[2] = '{1'b0, 2'b01, 4'b1001, 2'b01, 4'd2, 4'd0};
        vecs[3] = '{1'b0, 2'b01, 4'b0001, 2'b10, 4'd2, 4'd1};
        for (int r = 1; r <= 18; r++)
            vecs[3 + r] = '{(r == 1), 2'b00, 4'b1000, 2'b10, 4'd0, 4'((r > 15) ? 15 : r)};

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].do_rst)
                apply_reset();
            run_round(vecs[i].mv, vecs[i].ch, vecs[i].res, vecs[i].su, vecs[i].sc);
        end

        // Short glitch below the debounce length
        user_move = 2'b00;
        go_n = 1'b0;
        repeat (3) tick();
        go_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy) nb++;
        end
        chk("glitch_no_round", 32'(nb), 32'h0);

        // Invalid move press is dropped
        user_move = 2'b11;
        go_n = 1'b0;
        nb = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy || draw_start) nb++;
        end
        chk("invalid_no_round", 32'(nb), 32'h0);
        go_n = 1'b1;
        repeat (10) tick();

        // New press during WAIT_DONE, plus draw_done asserted in the DRAW cycle
        user_move = 2'b00;
        go_n = 1'b0;
        n = 0;
        while (!draw_start && n < 40) begin
            tick();
            n++;
        end
        chk("held_draw_seen", 32'(draw_start), 32'h1);
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("done_in_draw_ignored", 32'(busy), 32'h1);
        go_n = 1'b1;
        nds = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (draw_start) nds++;
        end
        go_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (draw_start) nds++;
        end
        chk("held_no_second_draw", 32'(nds), 32'h0);
        chk("held_still_busy", 32'(busy), 32'h1);
        go_n = 1'b1;
        repeat (10) tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("held_busy_fall", 32'(busy), 32'h0);
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (busy) nb++;
        end
        chk("held_not_queued", 32'(nb), 32'h0);

        // Reset asserted during WAIT_DONE after learning table[S][S]
        apply_reset();
        run_round(2'b01, 4'b1001, 2'b01, 4'd1, 4'd0);
        run_round(2'b01, 4'b1001, 2'b01, 4'd2, 4'd0);
        user_move = 2'b01;
        go_n = 1'b0;
        n = 0;
        while (!draw_start && n < 40) begin
            tick();
            n++;
        end
        chk("mid_draw_seen", 32'(choice), 32'b0001);
        tick();
        go_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_choice", 32'(choice), 32'h0);
        chk("mid_rst_result", 32'(result), 32'h0);
        chk("mid_rst_scores", 32'({score_u, score_c}), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ds", 32'(draw_start), 32'h0);
        tick();
        reset_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy || draw_start) nb++;
        end
        chk("mid_rst_quiet", 32'(nb), 32'h0);
        run_round(2'b01, 4'b1001, 2'b01, 4'd1, 4'd0);
        run_round(2'b00, 4'b1000, 2'b10, 4'd1, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
